// File: rtl/nios_qsys_shared_memory_pkg.sv
// Shared types for the shared-memory frame writer: FSM state encoding and
// the layout of the per-frame header word written in front of each payload.
package nios_qsys_shared_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_HDR  = 2'd2
  } fw_state_e;

  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_LEN_MSB   = 15;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_MAGIC_MSB = 31;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Header word: magic in the upper half, payload length in the lower half.
  typedef struct packed {
    logic [HDR_MAGIC_MSB-HDR_MAGIC_LSB:0] magic;
    logic [HDR_LEN_MSB-HDR_LEN_LSB:0]     len;
  } frame_hdr_t;

endpackage

// File: rtl/nios_qsys_ring_ptr.sv
// Ring pointer arithmetic: offset+wrap-bit pointers, next-slot increments,
// fill level and the two free-space thresholds used by the frame writer.
module nios_qsys_ring_ptr #(
  parameter int RING_DEPTH = 512,
  parameter int PTR_W      = $clog2(RING_DEPTH) + 1
) (
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr_p1,
  output logic [PTR_W-1:0] wr_ptr_p2,
  output logic             space_sop,
  output logic             space_data
);

  logic [PTR_W-1:0] used;

  // The extra wrap bit makes plain PTR_W-bit arithmetic wrap modulo 2*RING_DEPTH.
  assign wr_ptr_p1  = wr_ptr + PTR_W'(1);
  assign wr_ptr_p2  = wr_ptr + PTR_W'(2);
  assign used       = wr_ptr - rd_ptr;
  assign space_sop  = (used <= PTR_W'(RING_DEPTH - 2));
  assign space_data = (used <= PTR_W'(RING_DEPTH - 1));

endmodule

// File: rtl/nios_qsys_shared_memory_frame_writer.sv
// Packs an sop/eop word stream into a shared-memory ring: a header slot is
// reserved at sop, payload follows, and the header is written at eop to commit.
module nios_qsys_shared_memory_frame_writer
  import nios_qsys_shared_memory_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          RING_BASE  = 0,
  parameter int          RING_DEPTH = 512,
  parameter logic [15:0] HDR_MAGIC  = 16'hF5A0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  output logic [ADDR_W:0]   commit_ptr,
  output logic              frame_done,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W = $clog2(RING_DEPTH) + 1;
  localparam int OFF_W = PTR_W - 1;

  fw_state_e         state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  hdr_ptr_q, hdr_ptr_d;
  logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;

  logic [PTR_W-1:0]  rd_ptr_w;
  logic [PTR_W-1:0]  wr_ptr_p1, wr_ptr_p2;
  logic              space_sop, space_data;
  logic              ready_c;
  logic              unused_rd_ptr;
  frame_hdr_t        hdr_word;

  assign rd_ptr_w      = rd_ptr[PTR_W-1:0];
  assign unused_rd_ptr = ^rd_ptr;
  assign hdr_word      = '{magic: HDR_MAGIC, len: len_q};

  nios_qsys_ring_ptr #(
    .RING_DEPTH (RING_DEPTH),
    .PTR_W      (PTR_W)
  ) u_ring_ptr (
    .wr_ptr     (wr_ptr_q),
    .rd_ptr     (rd_ptr_w),
    .wr_ptr_p1  (wr_ptr_p1),
    .wr_ptr_p2  (wr_ptr_p2),
    .space_sop  (space_sop),
    .space_data (space_data)
  );

  function automatic logic [ADDR_W-1:0] ptr_addr(input logic [PTR_W-1:0] p);
    return ADDR_W'(RING_BASE) + ADDR_W'(p[OFF_W-1:0]);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    hdr_ptr_d    = hdr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    drop_cnt_d   = drop_cnt_q;
    frame_done_d = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    ready_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Words outside a frame are always swallowed; only a sop needs room for header+payload.
        ready_c = !in_sop || space_sop;
        if (in_valid && ready_c) begin
          if (in_sop) begin
            hdr_ptr_d  = wr_ptr_q;
            mem_wr_d   = 1'b1;
            mem_addr_d = ptr_addr(wr_ptr_p1);
            mem_data_d = in_data;
            wr_ptr_d   = wr_ptr_p2;
            len_d      = 16'd1;
            state_d    = in_eop ? ST_HDR : ST_DATA;
          end else if (drop_cnt_q != DROP_MAX) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      ST_DATA: begin
        ready_c = space_data;
        if (in_valid && ready_c) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = ptr_addr(wr_ptr_q);
          mem_data_d = in_data;
          wr_ptr_d   = wr_ptr_p1;
          len_d      = len_q + 16'd1;
          if (in_eop) state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        mem_wr_d     = 1'b1;
        mem_addr_d   = ptr_addr(hdr_ptr_q);
        mem_data_d   = hdr_word;
        commit_ptr_d = wr_ptr_q;
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      hdr_ptr_q    <= '0;
      commit_ptr_q <= '0;
      len_q        <= '0;
      drop_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      hdr_ptr_q    <= hdr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      len_q        <= len_d;
      drop_cnt_q   <= drop_cnt_d;
      frame_done_q <= frame_done_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign in_ready       = ready_c && !reset;
  assign mem_address    = mem_addr_q;
  assign mem_writedata  = mem_data_q;
  assign mem_byteenable = 4'hF;
  assign mem_chipselect = mem_wr_q;
  assign mem_write      = mem_wr_q;
  assign mem_clken      = 1'b1;
  assign commit_ptr     = (ADDR_W+1)'(commit_ptr_q);
  assign frame_done     = frame_done_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_nios_qsys_shared_memory_frame_writer.sv
// Bench for the frame writer: directed scenarios with literal expectations plus
// randomized frames, all checked every cycle against a slot-level ring model.
module tb_nios_qsys_shared_memory_frame_writer;

  localparam int          ADDR_W = 10;
  localparam int          BASE   = 0;
  localparam int          D      = 8;
  localparam int          P      = 2 * D;
  localparam logic [15:0] MAGIC  = 16'hF5A0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic [ADDR_W:0]   rd_ptr = '0;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_clken;
  logic [ADDR_W:0]   commit_ptr;
  logic              frame_done;
  logic [15:0]       drop_cnt;

  nios_qsys_shared_memory_frame_writer #(
    .ADDR_W     (ADDR_W),
    .RING_BASE  (BASE),
    .RING_DEPTH (D),
    .HDR_MAGIC  (MAGIC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .rd_ptr         (rd_ptr),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .commit_ptr     (commit_ptr),
    .frame_done     (frame_done),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;
  wr_t log_q[$];
  int  fd_cyc[$];
  int  fd_count = 0;
  int  cyc = 0;

  // Ring model: slot pointers as plain integers modulo 2*D.
  bit                model_valid = 0;
  int                m_wr, m_hdr, m_len, m_commit, m_drop;
  bit                m_in_frame, m_hdr_pend;
  bit                e_wr, e_fd;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_data;

  bit cons_en = 0;
  int rd_req  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wrap(input int v);
    return ((v % P) + P) % P;
  endfunction

  function automatic logic [ADDR_W-1:0] slot_addr(input int p);
    return ADDR_W'(BASE + (p % D));
  endfunction

  function automatic bit m_ready();
    int used;
    if (reset || m_hdr_pend) return 1'b0;
    used = wrap(m_wr - int'(rd_ptr));
    if (m_in_frame) return used <= D - 1;
    return !in_sop || used <= D - 2;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_wr = 0; m_hdr = 0; m_len = 0; m_commit = 0; m_drop = 0;
      m_in_frame = 0; m_hdr_pend = 0;
      e_wr = 0; e_fd = 0; e_addr = '0; e_data = '0;
      model_valid = 1;
    end else begin
      bit rdy;
      rdy  = m_ready();
      e_wr = 0;
      e_fd = 0;
      if (m_hdr_pend) begin
        e_wr = 1; e_addr = slot_addr(m_hdr); e_data = {MAGIC, 16'(m_len)};
        m_commit = m_wr; e_fd = 1; m_hdr_pend = 0;
      end else if (in_valid && rdy) begin
        if (m_in_frame) begin
          e_wr = 1; e_addr = slot_addr(m_wr); e_data = in_data;
          m_wr = wrap(m_wr + 1); m_len++;
          if (in_eop) begin m_in_frame = 0; m_hdr_pend = 1; end
        end else if (in_sop) begin
          m_hdr = m_wr;
          e_wr = 1; e_addr = slot_addr(m_wr + 1); e_data = in_data;
          m_wr = wrap(m_wr + 2); m_len = 1;
          if (in_eop) m_hdr_pend = 1; else m_in_frame = 1;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (model_valid) begin
      check("in_ready", 32'(in_ready), 32'(m_ready()));
      check("mem_write", 32'(mem_write), 32'(e_wr));
      check("mem_chipselect", 32'(mem_chipselect), 32'(e_wr));
      check("mem_byteenable", 32'(mem_byteenable), 32'hF);
      check("mem_clken", 32'(mem_clken), 32'd1);
      check("frame_done", 32'(frame_done), 32'(e_fd));
      check("commit_ptr", 32'(commit_ptr), 32'(m_commit));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (e_wr) begin
        check("mem_address", 32'(mem_address), 32'(e_addr));
        check("mem_writedata", mem_writedata, e_data);
      end
    end
    if (mem_write === 1'b1) log_q.push_back('{mem_address, mem_writedata});
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_cyc.push_back(cyc);
    end
  end

  // Consumer: either follows rd_req or randomly reads forward up to the committed pointer.
  always begin
    @(posedge clk);
    #1;
    if (!cons_en) rd_ptr = (ADDR_W+1)'(rd_req);
    else if ($urandom_range(3, 0) == 0)
      rd_ptr = (ADDR_W+1)'(wrap(int'(rd_ptr) +
               int'($urandom_range(wrap(m_commit - int'(rd_ptr)), 0))));
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic s, input logic e);
    bit r;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic chk_wr(input string nm, input int idx, input int a, input logic [31:0] d);
    check({nm, "_present"}, 32'(log_q.size() > idx), 32'd1);
    if (idx < log_q.size()) begin
      check({nm, "_addr"}, 32'(log_q[idx].a), 32'(a));
      check({nm, "_data"}, log_q[idx].d, d);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    cons_en = 0; rd_req = 0;
    idle(1);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    idle(1);
    reset = 1'b0;
    check("rst_commit", 32'(commit_ptr), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_writedata", mem_writedata, 32'd0);
    log_q.delete();
    fd_cyc.delete();
    fd_count = 0;
  endtask

  initial begin
    int len;
    bit s;

    // Three-word frame: payload at 1..3, header at 0.
    do_reset();
    send_word(32'hAAAA_0001, 1'b1, 1'b0);
    send_word(32'hBBBB_0002, 1'b0, 1'b0);
    send_word(32'hCCCC_0003, 1'b0, 1'b1);
    idle(5);
    check("t1_nwrites", 32'(log_q.size()), 32'd4);
    chk_wr("t1_w0", 0, 1, 32'hAAAA_0001);
    chk_wr("t1_w1", 1, 2, 32'hBBBB_0002);
    chk_wr("t1_w2", 2, 3, 32'hCCCC_0003);
    chk_wr("t1_hdr", 3, 0, 32'hF5A0_0003);
    check("t1_commit", 32'(commit_ptr), 32'd4);
    check("t1_frame_done", 32'(fd_count), 32'd1);

    // Single sop+eop word: payload at 5, header at 4, commit moves by 2.
    rd_req = 4;
    log_q.delete(); fd_count = 0;
    send_word(32'h1234_5678, 1'b1, 1'b1);
    idle(5);
    chk_wr("t2_w0", 0, 5, 32'h1234_5678);
    chk_wr("t2_hdr", 1, 4, 32'hF5A0_0001);
    check("t2_commit", 32'(commit_ptr), 32'd6);

    // Reset after the second word abandons the frame.
    do_reset();
    send_word(32'h0000_00A1, 1'b1, 1'b0);
    send_word(32'h0000_00A2, 1'b0, 1'b0);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    check("t3_nwrites", 32'(log_q.size()), 32'd2);
    check("t3_frame_done", 32'(fd_count), 32'd0);
    check("t3_commit", 32'(commit_ptr), 32'd0);
    log_q.delete();
    send_word(32'h0000_00B1, 1'b1, 1'b1);
    idle(5);
    chk_wr("t3_next_w0", 0, 1, 32'h0000_00B1);
    chk_wr("t3_next_hdr", 1, 0, 32'hF5A0_0001);

    // Back-to-back frames of 2 and 3 words.
    do_reset();
    send_word(32'h2000_0000, 1'b1, 1'b0);
    send_word(32'h2000_0001, 1'b0, 1'b1);
    send_word(32'h3000_0000, 1'b1, 1'b0);
    send_word(32'h3000_0001, 1'b0, 1'b0);
    send_word(32'h3000_0002, 1'b0, 1'b1);
    idle(6);
    chk_wr("t4_hdr0", 2, 0, 32'hF5A0_0002);
    chk_wr("t4_hdr1", 6, 3, 32'hF5A0_0003);
    check("t4_fd_count", 32'(fd_count), 32'd2);
    if (fd_cyc.size() == 2) check("t4_fd_gap", 32'(fd_cyc[1] - fd_cyc[0]), 32'd4);
    check("t4_commit", 32'(commit_ptr), 32'd7);

    // Nine-word frame into an 8-slot ring: stalls after 7, resumes once rd_ptr is 2.
    do_reset();
    send_word(32'h9000_0000, 1'b1, 1'b0);
    for (int k = 1; k < 7; k++) send_word(32'h9000_0000 + 32'(k), 1'b0, 1'b0);
    in_data = 32'h9000_0007; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
    idle(3);
    @(negedge clk);
    check("t5_full_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("t5_stall_writes", 32'(log_q.size()), 32'd7);
    rd_req = 2;
    send_word(32'h9000_0007, 1'b0, 1'b0);
    send_word(32'h9000_0008, 1'b0, 1'b1);
    idle(5);
    chk_wr("t5_w6", 6, 7, 32'h9000_0006);
    chk_wr("t5_w7", 7, 0, 32'h9000_0007);
    chk_wr("t5_w8", 8, 1, 32'h9000_0008);
    chk_wr("t5_hdr", 9, 0, 32'hF5A0_0009);
    check("t5_commit", 32'(commit_ptr), 32'd10);

    // Randomized frames with a lagging consumer and stray words between frames.
    do_reset();
    cons_en = 1;
    for (int f = 0; f < 250; f++) begin
      repeat ($urandom_range(2, 0))
        if ($urandom_range(3, 0) == 0) send_word($urandom, 1'b0, 1'($urandom_range(1, 0)));
      len = int'($urandom_range(6, 1));
      for (int w = 0; w < len; w++) begin
        s = (w == 0) || ($urandom_range(7, 0) == 0);
        send_word($urandom, s, 1'(w == len - 1));
        if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(2, 1)));
      end
    end
    idle(30);
    check("rand_frames", 32'(fd_count), 32'd250);

    // Stray words outside a frame: counted, never written, saturating at 16'hFFFF.
    do_reset();
    send_word(32'hDEAD_0001, 1'b0, 1'b0);
    send_word(32'hDEAD_0002, 1'b0, 1'b1);
    idle(2);
    check("t6_drop2", 32'(drop_cnt), 32'd2);
    check("t6_no_write", 32'(log_q.size()), 32'd0);
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
    idle(65533);
    in_valid = 1'b0;
    idle(1);
    check("t6_drop_max", 32'(drop_cnt), 32'h0000_FFFF);
    send_word(32'hDEAD_0003, 1'b0, 1'b0);
    send_word(32'hDEAD_0004, 1'b0, 1'b0);
    idle(2);
    check("t6_drop_sat", 32'(drop_cnt), 32'h0000_FFFF);
    check("t6_no_write_sat", 32'(log_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
